// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding an 8N1 serial transmitter (LSB first).
// A store-path write strobe pushes bytes into the FIFO. The transmitter pops the
// head whenever it is idle, or at the end of a stop bit, so queued frames go out
// back-to-back with no idle gap between them.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   wr_en, wr_data     single-cycle write strobe and the byte to queue
//   clr_ovf            clears the sticky overflow flag (a dropped write on the same edge wins)
//   tx                 serial line, idles high, driven from a flop
//   busy               high while a start, data or stop bit is on the line
//   full, empty, count registered FIFO occupancy status
//   overflow           sticky flag, set when a write arrives while the FIFO is full
module uart_tx_fifo #(
  parameter int unsigned clks_per_bit = 868,
  parameter int unsigned fifo_depth   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [7:0]                         wr_data,
  input  logic                               clr_ovf,
  output logic                               tx,
  output logic                               busy,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(fifo_depth+1)-1:0]    count,
  output logic                               overflow
);

  localparam int unsigned cnt_w  = $clog2(fifo_depth + 1);
  localparam int unsigned ptr_w  = $clog2(fifo_depth);
  localparam int unsigned baud_w = $clog2(clks_per_bit);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [baud_w-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          sh_q, sh_d;
  logic                tx_d, busy_d;

  logic [7:0]          mem [fifo_depth];
  logic [ptr_w-1:0]    rd_ptr, wr_ptr;
  logic [cnt_w-1:0]    count_d;
  logic                overflow_d;

  logic                pop_c;
  logic                push_c;
  logic                bit_end_c;
  logic [7:0]          head_c;

  // full is the pre-edge value, so a pop on the same edge never rescues a write
  assign push_c    = wr_en & ~full;
  assign bit_end_c = (baud_q == baud_w'(clks_per_bit - 1));
  assign head_c    = mem[rd_ptr];

  // Transmitter next-state and line outputs
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx;
    busy_d  = busy;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        if (!empty) begin
          pop_c   = 1'b1;
          sh_d    = head_c;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + baud_w'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // sh[1] becomes the new LSB after the shift
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + baud_w'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (!empty) begin
            pop_c   = 1'b1;
            sh_d    = head_c;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + baud_w'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO occupancy and sticky overflow next values
  always_comb begin
    count_d = count;
    case ({push_c, pop_c})
      2'b10:   count_d = count + cnt_w'(1);
      2'b01:   count_d = count - cnt_w'(1);
      default: count_d = count;
    endcase
    overflow_d = overflow;
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // State, pointers and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      sh_q     <= 8'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx       <= tx_d;
      busy     <= busy_d;
      count    <= count_d;
      full     <= (count_d == cnt_w'(fifo_depth));
      empty    <= (count_d == '0);
      overflow <= overflow_d;
      // power-of-two depth: pointers wrap by natural overflow
      if (push_c) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ptr_w'(1);
    end
  end

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo (clks_per_bit=4, fifo_depth=8).
// A queue-plus-frame-timer model predicts every output, checked on each falling
// edge, alongside hand-computed literal expectations at key cycles.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk, rst, wr_en, clr_ovf;
  logic [7:0] wr_data;
  logic       tx, busy, full, empty, overflow;
  logic [3:0] count;

  int nchk = 0;
  int nerr = 0;

  uart_tx_fifo #(.clks_per_bit(CPB), .fifo_depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .tx(tx), .busy(busy), .full(full), .empty(empty), .count(count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending bytes plus the frame currently on the line,
  // tracked as a cycle offset into a 10-bit-time frame.
  logic [7:0] q[$];
  logic [7:0] m_byte;
  bit         m_active;
  int         m_t;
  bit         m_ovf;
  int         m_sz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_active = 0;
      m_t      = 0;
      m_ovf    = 0;
      m_byte   = 8'h00;
    end else begin
      m_sz = q.size();
      if (m_active) begin
        if (m_t == FRAME - 1) begin
          if (m_sz > 0) begin
            m_byte = q.pop_front();
            m_t    = 0;
          end else begin
            m_active = 0;
          end
        end else begin
          m_t++;
        end
      end else if (m_sz > 0) begin
        m_byte   = q.pop_front();
        m_active = 1;
        m_t      = 0;
      end
      if (wr_en && m_sz == DEPTH) m_ovf = 1;
      else if (clr_ovf)           m_ovf = 0;
      if (wr_en && m_sz < DEPTH) q.push_back(wr_data);
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  bit t6;
  int maxc;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_tx",    32'(tx),       32'(exp_tx()));
    chk("m_busy",  32'(busy),     32'(m_active));
    chk("m_count", 32'(count),    32'(q.size()));
    chk("m_empty", 32'(empty),    32'(q.size() == 0));
    chk("m_full",  32'(full),     32'(q.size() == DEPTH));
    chk("m_ovf",   32'(overflow), 32'(m_ovf));
    if (t6 && int'(count) > maxc) maxc = int'(count);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    t6 = 0; maxc = 0;
    cyc(2);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    cyc(1);

    // 1: single byte 0xA5, edge 0 = first edge with wr_en
    wr_en = 1'b1; wr_data = 8'hA5;
    cyc(1); wr_en = 1'b0;
    chk("t1_e0_count", 32'(count), 32'd1);
    chk("t1_e0_tx", 32'(tx), 32'd1);
    cyc(1);
    chk("t1_e1_tx", 32'(tx), 32'd0);
    chk("t1_e1_busy", 32'(busy), 32'd1);
    chk("t1_e1_count", 32'(count), 32'd0);
    cyc(3);  chk("t1_e4_tx", 32'(tx), 32'd0);
    cyc(1);  chk("t1_e5_tx", 32'(tx), 32'd1);
    cyc(4);  chk("t1_e9_tx", 32'(tx), 32'd0);
    cyc(28); chk("t1_e37_tx", 32'(tx), 32'd1);
    cyc(3);  chk("t1_e40_busy", 32'(busy), 32'd1);
    cyc(1);  chk("t1_e41_busy", 32'(busy), 32'd0);
    cyc(4);

    // 2: ten back-to-back writes, the tenth is dropped
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      cyc(1);
      if (i == 8) begin
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count8", 32'(count), 32'd8);
      end
    end
    wr_en = 1'b0;
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count_after_drop", 32'(count), 32'd8);
    cyc(9 * FRAME + 10);
    chk("t2_drained", 32'(empty), 32'd1);

    // 3: clear overflow, then clear coincident with a dropped write
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    chk("t3_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      clr_ovf = (i == 9);
      cyc(1);
    end
    wr_en = 1'b0; clr_ovf = 1'b0;
    chk("t3_set_wins", 32'(overflow), 32'd1);

    // 4: write on the edge where STOP ends and pops, while full
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    n = 0;
    while (!(m_active && m_t == FRAME - 1) && n < 200) begin
      cyc(1); n++;
    end
    chk("t4_found_stop_end", 32'(n < 200), 32'd1);
    chk("t4_full_before", 32'(count), 32'd8);
    wr_en = 1'b1; wr_data = 8'hEE;
    cyc(1); wr_en = 1'b0;
    chk("t4_count7", 32'(count), 32'd7);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_new_start", 32'(tx), 32'd0);
    cyc(8 * FRAME + 10);
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;

    // 5: asynchronous reset during data bit 3 of 0xFF
    wr_en = 1'b1; wr_data = 8'hFF; cyc(1);
    wr_data = 8'h11; cyc(1); wr_en = 1'b0;
    cyc(17);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    chk("t5_count_pre", 32'(count), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_tx", 32'(tx), 32'd1);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_count", 32'(count), 32'd0);
    chk("t5_async_empty", 32'(empty), 32'd1);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    wr_en = 1'b1; wr_data = 8'h3C; cyc(1); wr_en = 1'b0;
    cyc(1);  chk("t5_start", 32'(tx), 32'd0);
    cyc(4);  chk("t5_bit0", 32'(tx), 32'd0);
    cyc(8);  chk("t5_bit2", 32'(tx), 32'd1);
    cyc(30); chk("t5_done", 32'(busy), 32'd0);

    // 6: twenty writes spaced a frame apart exercise pointer wrap
    t6 = 1;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(i * 29 + 7);
      cyc(1); wr_en = 1'b0;
      cyc(FRAME + 1);
    end
    t6 = 0;
    chk("t6_max_count", 32'(maxc), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
